// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM stage
// and the debug/loader port. The CPU has priority. The debug port wins once it
// has lost STARVE_MAX consecutive conflicts. One access is in flight at a time.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no access in flight; arbitrate and capture the winner's request
// S_BUSY | memory access in progress; lat_cnt counts down the read latency
// S_RESP | ack pulse to the owning port; requests are not sampled here
module dmem_arbiter #(
  parameter int Nbits      = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [Nbits-1:0] cpu_addr,
  input  logic [Nbits-1:0] cpu_wdata,
  output logic             cpu_ack,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [Nbits-1:0] dbg_addr,
  input  logic [Nbits-1:0] dbg_wdata,
  output logic             dbg_ack,
  output logic [Nbits-1:0] rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [Nbits-1:0] mem_addr,
  output logic [Nbits-1:0] mem_wdata,
  input  logic [Nbits-1:0] mem_rdata,
  output logic             owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [Nbits-1:0] addr_q, addr_d;
  logic [Nbits-1:0] wdata_q, wdata_d;
  logic [Nbits-1:0] rdata_q, rdata_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [3:0]       starve_cnt_q, starve_cnt_d;
  logic             grant_dbg;
  logic             first_busy;

  // The counter still holds its load value only during the first BUSY cycle,
  // which is where a write strobe is issued.
  assign first_busy = (lat_cnt_q == LAT_LOAD);

  // Next-state, arbitration and memory-port strobes.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    grant_dbg    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    cpu_ack      = 1'b0;
    dbg_ack      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          grant_dbg = dbg_req && (!cpu_req || (starve_cnt_q == STARVE_LIM));
          if (grant_dbg) begin
            starve_cnt_d = 4'd0;
            we_d         = dbg_we;
            addr_d       = dbg_addr;
            wdata_d      = dbg_wdata;
          end else begin
            // A CPU win only counts against the debug port if it was waiting.
            if (!dbg_req) begin
              starve_cnt_d = 4'd0;
            end else if (starve_cnt_q < STARVE_LIM) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
          owner_d   = grant_dbg;
          lat_cnt_d = LAT_LOAD;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        mem_read  = ~we_q;
        mem_write = we_q & first_busy;
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q == 3'd1) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cpu_ack = ~owner_q;
        dbg_ack = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign owner     = owner_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model
// that schedules each granted access by cycle number.
module tb_dmem_arbiter;
  localparam int NB   = 64;
  localparam int LAT  = 1;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Main DUT signals
  logic          rst, cpu_req, cpu_we, dbg_req, dbg_we;
  logic [NB-1:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic          cpu_ack, cpu_stall, dbg_ack, mem_read, mem_write, owner;
  logic [NB-1:0] rdata, mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT=3 instance signals
  logic          l3_rst, l3_cpu_req, l3_cpu_we, l3_dbg_req, l3_dbg_we;
  logic [NB-1:0] l3_cpu_addr, l3_cpu_wdata, l3_dbg_addr, l3_dbg_wdata;
  logic          l3_cpu_ack, l3_cpu_stall, l3_dbg_ack, l3_mem_read, l3_mem_write, l3_owner;
  logic [NB-1:0] l3_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

  dmem_arbiter #(.Nbits(NB), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  dmem_arbiter #(.Nbits(NB), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_lat3 (
    .clk(clk), .rst(l3_rst),
    .cpu_req(l3_cpu_req), .cpu_we(l3_cpu_we), .cpu_addr(l3_cpu_addr), .cpu_wdata(l3_cpu_wdata),
    .cpu_ack(l3_cpu_ack), .cpu_stall(l3_cpu_stall),
    .dbg_req(l3_dbg_req), .dbg_we(l3_dbg_we), .dbg_addr(l3_dbg_addr), .dbg_wdata(l3_dbg_wdata),
    .dbg_ack(l3_dbg_ack), .rdata(l3_rdata),
    .mem_read(l3_mem_read), .mem_write(l3_mem_write), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata), .owner(l3_owner)
  );

  // Bench memory behind the main DUT: asynchronous read, write on the strobe.
  logic [NB-1:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

  // The LAT=3 instance sees a value that changes every cycle.
  assign l3_mem_rdata = 64'hA500 + 64'(cyc);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  logic [NB-1:0] model_mem [0:255];
  bit            t_valid = 1'b0, t_dbg = 1'b0, t_we = 1'b0;
  int            t_start = 0;
  logic [NB-1:0] t_addr = '0, t_wdata = '0;
  int            m_free = 0;
  bit            m_owner = 1'b0;
  logic [NB-1:0] m_rdata = '0;
  int            m_starve = 0;
  bit            e_cpu_ack = 1'b0, e_dbg_ack = 1'b0, e_rd = 1'b0, e_wr = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      model_mem[i] = '0;
    end
    mem[8'h10] = 64'hDEAD;  model_mem[8'h10] = 64'hDEAD;
    mem[8'h40] = 64'h4040;  model_mem[8'h40] = 64'h4040;
  end

  // Compare process: expectations for this cycle, compare, then apply the edge.
  always @(negedge clk) begin
    bit win_dbg;
    if (cyc >= 1) begin
      e_cpu_ack = 1'b0; e_dbg_ack = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      if (t_valid) begin
        if (!t_we && cyc > t_start && cyc <= t_start + LAT) e_rd = 1'b1;
        if (t_we && cyc == t_start + 1) e_wr = 1'b1;
        if (cyc == t_start + LAT + 1) begin
          if (t_dbg) e_dbg_ack = 1'b1; else e_cpu_ack = 1'b1;
          if (!t_we) m_rdata = model_mem[t_addr[7:0]];
        end
      end
      check("m_cpu_ack", cpu_ack, e_cpu_ack);
      check("m_dbg_ack", dbg_ack, e_dbg_ack);
      check("m_mem_read", mem_read, e_rd);
      check("m_mem_write", mem_write, e_wr);
      check("m_owner", owner, m_owner);
      check("m_rdata", rdata, m_rdata);
      check("m_cpu_stall", cpu_stall, cpu_req & ~e_cpu_ack);
      if (e_rd || e_wr) check("m_mem_addr", mem_addr, t_addr);
      if (e_wr) check("m_mem_wdata", mem_wdata, t_wdata);

      if (rst) begin
        t_valid = 1'b0; m_free = cyc + 1; m_owner = 1'b0; m_rdata = '0; m_starve = 0;
      end else if (cyc >= m_free && (cpu_req || dbg_req)) begin
        win_dbg = dbg_req && (!cpu_req || m_starve == SMAX);
        if (win_dbg || !dbg_req) m_starve = 0;
        else if (m_starve < SMAX) m_starve = m_starve + 1;
        t_valid = 1'b1; t_start = cyc; t_dbg = win_dbg;
        t_we    = win_dbg ? dbg_we    : cpu_we;
        t_addr  = win_dbg ? dbg_addr  : cpu_addr;
        t_wdata = win_dbg ? dbg_wdata : cpu_wdata;
        m_owner = win_dbg;
        m_free  = cyc + LAT + 2;
        if (t_we) model_mem[t_addr[7:0]] = t_wdata;
      end
    end
  end

  // ---------------- MEM_LAT=3 directed read ----------------
  initial begin
    logic [NB-1:0] v3;
    l3_rst = 1'b1; l3_cpu_req = 1'b0; l3_cpu_we = 1'b0; l3_cpu_addr = '0; l3_cpu_wdata = '0;
    l3_dbg_req = 1'b0; l3_dbg_we = 1'b0; l3_dbg_addr = '0; l3_dbg_wdata = '0;
    v3 = '0;
    repeat (3) tick();
    l3_rst = 1'b0; l3_cpu_req = 1'b1; l3_cpu_addr = 64'h8;
    at_neg();
    check("l3_idle_read", l3_mem_read, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      at_neg();
      check("l3_busy_read", l3_mem_read, 1'b1);
      check("l3_busy_noack", l3_cpu_ack, 1'b0);
      check("l3_busy_addr", l3_mem_addr, 64'h8);
      if (i == 3) v3 = 64'hA500 + 64'(cyc);
    end
    tick();
    at_neg();
    check("l3_ack", l3_cpu_ack, 1'b1);
    check("l3_resp_read", l3_mem_read, 1'b0);
    check("l3_rdata", l3_rdata, v3);
    check("l3_stall", l3_cpu_stall, 1'b0);
    check("l3_others", {l3_dbg_ack, l3_mem_write, l3_owner}, 3'b000);
    check("l3_wdata", l3_mem_wdata, 64'h0);
    tick();
    l3_cpu_req = 1'b0;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int k, n, last;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (2) tick();
    at_neg();
    check("rst_outputs", {cpu_ack, dbg_ack, mem_read, mem_write, owner, cpu_stall}, 6'b0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_addr", mem_addr, 64'h0);

    // CPU read of 0x10
    tick(); rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
    at_neg(); check("t1_stall_c0", cpu_stall, 1'b1); check("t1_read_c0", mem_read, 1'b0);
    tick(); at_neg();
    check("t1_read_c1", mem_read, 1'b1); check("t1_stall_c1", cpu_stall, 1'b1);
    check("t1_noack_c1", cpu_ack, 1'b0);
    tick(); at_neg();
    check("t1_ack_c2", cpu_ack, 1'b1); check("t1_rdata", rdata, 64'hDEAD);
    check("t1_stall_c2", cpu_stall, 1'b0);
    tick(); cpu_req = 1'b0;

    // Debug write 0x55 to 0x20, then CPU read back
    tick(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 64'h20; dbg_wdata = 64'h55;
    at_neg(); check("t2_wr_c0", mem_write, 1'b0);
    tick(); at_neg();
    check("t2_wr_c1", mem_write, 1'b1); check("t2_wr_addr", mem_addr, 64'h20);
    check("t2_wr_data", mem_wdata, 64'h55); check("t2_wr_noread", mem_read, 1'b0);
    tick(); at_neg();
    check("t2_wr_c2", mem_write, 1'b0); check("t2_dbg_ack", dbg_ack, 1'b1);
    tick(); dbg_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h20;
    at_neg();
    tick(); at_neg(); check("t2_rd_c4", mem_read, 1'b1);
    tick(); at_neg();
    check("t2_cpu_ack_c5", cpu_ack, 1'b1); check("t2_rdata", rdata, 64'h55);
    tick(); cpu_req = 1'b0;

    // Both ports requesting continuously: starvation order and back-to-back spacing
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h30;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 64'h40;
    k = 0; n = 0; last = 0;
    while (k < 10 && n < 60) begin
      at_neg();
      if (cpu_ack || dbg_ack) begin
        check("t3_winner_dbg", dbg_ack, 1'((k % 5) == 4));
        check("t3_owner", owner, 1'((k % 5) == 4));
        if (k > 0) check("t3_ack_spacing", 64'(cyc - last), 64'(LAT + 2));
        last = cyc;
        k++;
      end
      n++;
      if (k < 10) tick();
    end
    check("t3_ack_count", 64'(k), 64'd10);
    check("t3_last_rdata", rdata, 64'h4040);
    tick(); cpu_req = 1'b0; dbg_req = 1'b0;

    // Reset in the BUSY cycle of a CPU read
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h10;
    at_neg();
    tick(); rst = 1'b1;
    at_neg(); check("t5_busy_read", mem_read, 1'b1);
    tick(); rst = 1'b0; cpu_req = 1'b0;
    at_neg();
    check("t5_idle_read", mem_read, 1'b0); check("t5_idle_owner", owner, 1'b0);
    check("t5_idle_rdata", rdata, 64'h0); check("t5_noack", cpu_ack, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); at_neg(); check("t5_noack_later", cpu_ack, 1'b0);
    end
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h20;
    at_neg();
    tick(); at_neg();
    tick(); at_neg();
    check("t5_fresh_ack", cpu_ack, 1'b1); check("t5_fresh_rdata", rdata, 64'h55);
    tick(); cpu_req = 1'b0;

    // Randomized traffic; requesters react to the model's acks from the last cycle
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      if (cpu_req && e_cpu_ack) cpu_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 99) < 45) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 64'($urandom_range(0, 31)) << 3;
        cpu_wdata = {$urandom(), $urandom()};
      end
      if (dbg_req && e_dbg_ack) dbg_req = 1'b0;
      if (!dbg_req && $urandom_range(0, 99) < 35) begin
        dbg_req   = 1'b1;
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 64'($urandom_range(0, 31)) << 3;
        dbg_wdata = {$urandom(), $urandom()};
      end
    end
    tick(); rst = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    repeat (8) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
